// File: rtl/instr_feed_server.sv
// Instruction feed server: host-loaded program store served to a core
// over a PC/instruction pair, with run control, cycle counting and timeout.
module instr_feed_server #(
    parameter int          N           = 512,
    parameter logic [31:0] STOP_OPCODE = 32'd6,
    parameter int          MAX_CYCLES  = 100000,
    localparam int         AW          = $clog2(N)
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    input  logic          host_clear,
    input  logic          host_start,
    output logic          host_busy,
    output logic          host_done,
    output logic          host_err,
    output logic [AW:0]   prog_len,
    output logic [31:0]   cycle_count,
    input  logic [AW-1:0] PC_AXI,
    output logic [31:0]   INSTR_AXI,
    output logic          START_SIGNAL,
    input  logic          STOP_SIGNAL
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [31:0] mem [N];

    logic [AW:0] addr_len;
    logic [AW:0] base_len;
    logic [AW:0] len_next;
    logic [31:0] cnt_next;
    logic        timeout;
    logic        fetch_ok;

    // A write in the same cycle as start is counted before the start check.
    always_comb begin
        addr_len = {1'b0, host_addr} + {{AW{1'b0}}, 1'b1};
        base_len = host_clear ? '0 : prog_len;
        len_next = base_len;
        if (host_we && addr_len > base_len)
            len_next = addr_len;
        cnt_next = (cycle_count == '1) ? cycle_count
                                       : cycle_count + 32'd1;
        timeout  = cnt_next >= 32'(MAX_CYCLES);
        fetch_ok = {1'b0, PC_AXI} < prog_len;
    end

    always_ff @(posedge CLK) begin
        if (RSTN && host_we && state != RUN)
            mem[host_addr] <= host_wdata;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state        <= IDLE;
            INSTR_AXI    <= '0;
            START_SIGNAL <= 1'b0;
            host_busy    <= 1'b0;
            host_done    <= 1'b0;
            host_err     <= 1'b0;
            prog_len     <= '0;
            cycle_count  <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    prog_len  <= len_next;
                    INSTR_AXI <= '0;
                    if (host_start && len_next != '0) begin
                        state        <= RUN;
                        START_SIGNAL <= 1'b1;
                        host_busy    <= 1'b1;
                        host_done    <= 1'b0;
                        host_err     <= 1'b0;
                        cycle_count  <= '0;
                    end else if (host_clear) begin
                        state     <= IDLE;
                        host_done <= 1'b0;
                        host_err  <= 1'b0;
                    end
                end
                RUN: begin
                    cycle_count <= cnt_next;
                    // Stop takes priority over a coincident timeout.
                    if (STOP_SIGNAL || timeout) begin
                        state        <= DONE;
                        START_SIGNAL <= 1'b0;
                        host_busy    <= 1'b0;
                        INSTR_AXI    <= '0;
                        host_done    <= STOP_SIGNAL;
                        host_err     <= !STOP_SIGNAL;
                    end else begin
                        INSTR_AXI <= fetch_ok ? mem[PC_AXI]
                                              : STOP_OPCODE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_feed_server.sv
// Scoreboard bench for instr_feed_server: program load, fetch latency,
// stop/timeout, ignored host traffic in RUN, clear and reset.
module tb_instr_feed_server;
    localparam int N    = 16;
    localparam int AW   = 4;
    localparam int MAXC = 50;

    logic          CLK = 1'b0;
    logic          RSTN = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [31:0]   host_wdata = '0;
    logic          host_clear = 1'b0;
    logic          host_start = 1'b0;
    logic          host_busy;
    logic          host_done;
    logic          host_err;
    logic [AW:0]   prog_len;
    logic [31:0]   cycle_count;
    logic [AW-1:0] PC_AXI = '0;
    logic [31:0]   INSTR_AXI;
    logic          START_SIGNAL;
    logic          STOP_SIGNAL = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_len = 0;
    logic [31:0] model [N];
    logic [31:0] exp_q [$];

    instr_feed_server #(
        .N(N), .STOP_OPCODE(32'd6), .MAX_CYCLES(MAXC)
    ) dut (
        .CLK(CLK), .RSTN(RSTN),
        .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_clear(host_clear),
        .host_start(host_start), .host_busy(host_busy),
        .host_done(host_done), .host_err(host_err),
        .prog_len(prog_len), .cycle_count(cycle_count),
        .PC_AXI(PC_AXI), .INSTR_AXI(INSTR_AXI),
        .START_SIGNAL(START_SIGNAL), .STOP_SIGNAL(STOP_SIGNAL)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        host_we = 1'b1;
        host_addr = AW'(a);
        host_wdata = d;
        step();
        host_we = 1'b0;
        model[a] = d;
        if (a + 1 > model_len) model_len = a + 1;
    endtask

    task automatic load_prog();
        write_word(0, 32'h2322);
        write_word(1, 32'h0722);
        write_word(2, 32'h2BA3);
        write_word(3, 32'h0FA3);
        write_word(4, 32'h0004);
    endtask

    task automatic start_run();
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        cyc = 0;
        checks++;
        if ({START_SIGNAL, host_busy, host_done, host_err} !== 4'b1100 ||
            cycle_count !== 32'd0) begin
            errors++;
            $display("FAIL start got s=%b b=%b d=%b e=%b c=%0d exp 1100 c=0",
                     START_SIGNAL, host_busy, host_done, host_err,
                     cycle_count);
        end
    endtask

    task automatic fetch(input int pc);
        logic [31:0] e;
        PC_AXI = AW'(pc);
        exp_q.push_back(pc < model_len ? model[pc] : 32'd6);
        step();
        cyc++;
        e = exp_q.pop_front();
        checks++;
        if (INSTR_AXI !== e) begin
            errors++;
            $display("FAIL fetch pc=%0d got %h exp %h", pc, INSTR_AXI, e);
        end
        checks++;
        if (cycle_count !== 32'(cyc)) begin
            errors++;
            $display("FAIL count got %0d exp %0d", cycle_count, cyc);
        end
    endtask

    task automatic stop_run();
        STOP_SIGNAL = 1'b1;
        step();
        STOP_SIGNAL = 1'b0;
        cyc++;
        checks++;
        if ({START_SIGNAL, host_busy, host_done, host_err} !== 4'b0010 ||
            INSTR_AXI !== 32'd0 || cycle_count !== 32'(cyc)) begin
            errors++;
            $display("FAIL stop got s=%b b=%b d=%b e=%b i=%h c=%0d exp 0010 i=0 c=%0d",
                     START_SIGNAL, host_busy, host_done, host_err,
                     INSTR_AXI, cycle_count, cyc);
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        step();
        step();
        checks++;
        if ({INSTR_AXI, START_SIGNAL, host_busy, host_done, host_err,
             prog_len, cycle_count} !== '0) begin
            errors++;
            $display("FAIL reset got i=%h s=%b b=%b d=%b e=%b l=%0d c=%0d exp 0",
                     INSTR_AXI, START_SIGNAL, host_busy, host_done,
                     host_err, prog_len, cycle_count);
        end
        RSTN = 1'b1;
        step();
    endtask

    task automatic test_fetch();
        load_prog();
        checks++;
        if (prog_len !== 5'd5) begin
            errors++;
            $display("FAIL prog_len got %0d exp 5", prog_len);
        end
        start_run();
        for (int p = 0; p < 5; p++) fetch(p);
    endtask

    task automatic test_stop();
        fetch(7);
        fetch(5);
        while (cyc < 19) fetch(cyc % 5);
        stop_run();
    endtask

    task automatic test_timeout();
        int n;
        start_run();
        fetch(3);
        n = 1;
        for (int i = 0; i < 200; i++) begin
            step();
            n++;
            if (!host_busy) break;
        end
        checks++;
        if (n !== MAXC || host_done !== 1'b0 || host_err !== 1'b1 ||
            START_SIGNAL !== 1'b0 || cycle_count !== 32'(MAXC)) begin
            errors++;
            $display("FAIL timeout got n=%0d d=%b e=%b s=%b c=%0d exp n=50 d=0 e=1 s=0 c=50",
                     n, host_done, host_err, START_SIGNAL, cycle_count);
        end
        start_run();
        repeat (MAXC - 1) step();
        cyc = MAXC - 1;
        checks++;
        if (host_busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_timeout busy got %b exp 1", host_busy);
        end
        stop_run();
    endtask

    task automatic test_run_ignore();
        start_run();
        fetch(0);
        host_we = 1'b1;
        host_addr = 4'd2;
        host_wdata = 32'hFFFF;
        host_start = 1'b1;
        host_clear = 1'b1;
        step();
        cyc++;
        host_we = 1'b0;
        host_start = 1'b0;
        host_clear = 1'b0;
        checks++;
        if (prog_len !== 5'd5 || host_busy !== 1'b1 ||
            cycle_count !== 32'(cyc)) begin
            errors++;
            $display("FAIL run_ignore got l=%0d b=%b c=%0d exp l=5 b=1 c=%0d",
                     prog_len, host_busy, cycle_count, cyc);
        end
        fetch(2);
        stop_run();
    endtask

    task automatic test_clear_and_reset();
        host_clear = 1'b1;
        step();
        host_clear = 1'b0;
        model_len = 0;
        checks++;
        if ({prog_len, host_busy, host_done, host_err} !== '0) begin
            errors++;
            $display("FAIL clear got l=%0d b=%b d=%b e=%b exp 0",
                     prog_len, host_busy, host_done, host_err);
        end
        host_start = 1'b1;
        step();
        host_start = 1'b0;
        checks++;
        if (START_SIGNAL !== 1'b0 || host_busy !== 1'b0) begin
            errors++;
            $display("FAIL empty_start got s=%b b=%b exp 0 0",
                     START_SIGNAL, host_busy);
        end
        host_we = 1'b1;
        host_addr = '0;
        host_wdata = 32'h2322;
        host_start = 1'b1;
        step();
        host_we = 1'b0;
        host_start = 1'b0;
        model[0] = 32'h2322;
        model_len = 1;
        cyc = 0;
        checks++;
        if (host_busy !== 1'b1 || prog_len !== 5'd1) begin
            errors++;
            $display("FAIL we_start got b=%b l=%0d exp b=1 l=1",
                     host_busy, prog_len);
        end
        fetch(0);
        fetch(1);
        while (cyc < 10) fetch(2);
        RSTN = 1'b0;
        step();
        checks++;
        if ({INSTR_AXI, START_SIGNAL, host_busy, host_done, host_err,
             prog_len, cycle_count} !== '0) begin
            errors++;
            $display("FAIL mid_reset got i=%h s=%b b=%b l=%0d c=%0d exp 0",
                     INSTR_AXI, START_SIGNAL, host_busy, prog_len,
                     cycle_count);
        end
        RSTN = 1'b1;
        model_len = 0;
        PC_AXI = '0;
        step();
        checks++;
        if (INSTR_AXI !== 32'd0 || START_SIGNAL !== 1'b0 ||
            prog_len !== 5'd0) begin
            errors++;
            $display("FAIL post_reset got i=%h s=%b l=%0d exp 0",
                     INSTR_AXI, START_SIGNAL, prog_len);
        end
        load_prog();
        start_run();
        fetch(0);
        fetch(4);
        stop_run();
    endtask

    task automatic test_full();
        host_clear = 1'b1;
        step();
        host_clear = 1'b0;
        model_len = 0;
        for (int i = 0; i < N; i++) write_word(i, 32'hA000 + 32'(i));
        checks++;
        if (prog_len !== 5'd16) begin
            errors++;
            $display("FAIL full_len got %0d exp 16", prog_len);
        end
        start_run();
        fetch(15);
        fetch(0);
        stop_run();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_stop();
        test_timeout();
        test_run_ignore();
        test_clear_and_reset();
        test_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
